axi_lite_sram: RTL

AXI-lite style memory responder: the slave end of the aw/w/b/ar/r channels the multicycle core's MEM/WBU path drives as initiator.
Word-organised SRAM model with independent read and write engines and a configurable response latency.
Out-of-range accesses return an error response.
Sits beneath the core top as the data-memory backend; a second instance can serve IFU fetch.

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/lfsr8.sv | 19 +
 rtl/axi_lite_sram.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes, engine state types and address-range helper for the
// AXI-lite SRAM responder.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

    // Widened to 64 bits so base + 4*depth cannot wrap at the top of the map.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] depth);
        return (addr >= base) && (addr < base + (depth << 2));
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Galois LFSR (taps 8'hB8, seed 8'hA5) used to jitter SRAM response latency.
// Only compiled when SRAM_RAND_DELAY_EN is defined.
`ifdef SRAM_RAND_DELAY_EN
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 8'hA5;
        end else begin
            value <= {1'b0, value[7:1]} ^ (value[0] ? 8'hB8 : 8'h00);
        end
    end

endmodule
`endif

// File: rtl/axi_lite_sram.sv
// AXI-lite word SRAM responder with independent read/write engines and fixed latency.
// Define SRAM_RAND_DELAY_EN to add 0..3 LFSR-driven extra wait cycles per transaction.
module axi_lite_sram
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                RD_LAT    = 1,
    parameter int                WR_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_awvalid,
    output logic              mem_awready,
    input  logic [ADDR_W-1:0] mem_awaddr,
    input  logic              mem_wvalid,
    output logic              mem_wready,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [7:0]        mem_wstrb,
    output logic              mem_bvalid,
    input  logic              mem_bready,
    output logic [1:0]        mem_bresp,
    input  logic              mem_arvalid,
    output logic              mem_arready,
    input  logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_rvalid,
    input  logic              mem_rready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mem_rresp
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 8;

    logic [DATA_W-1:0] mem [DEPTH];

    rd_state_t         rd_state;
    logic [CNT_W-1:0]  rd_cnt;
    logic [ADDR_W-1:0] raddr;

    wr_state_t         wr_state;
    logic [CNT_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;

    logic [CNT_W-1:0]  rd_load;
    logic [CNT_W-1:0]  wr_load;
    logic              aw_got;
    logic              w_got;
    logic              wr_commit;
    logic              wstrb_hi_unused;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return in_range(64'(a), 64'(BASE_ADDR), 64'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    assign wstrb_hi_unused = ^mem_wstrb[7:4];

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;
    logic       lfsr_hi_unused;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    // Both engines sample the same jitter if they load on the same edge.
    assign rd_load        = CNT_W'(RD_LAT) + CNT_W'(lfsr[1:0]);
    assign wr_load        = CNT_W'(WR_LAT) + CNT_W'(lfsr[1:0]);
    assign lfsr_hi_unused = ^lfsr[7:2];
`else
    assign rd_load = CNT_W'(RD_LAT);
    assign wr_load = CNT_W'(WR_LAT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state    <= R_IDLE;
            rd_cnt      <= '0;
            raddr       <= '0;
            mem_arready <= 1'b1;
            mem_rvalid  <= 1'b0;
            mem_rdata   <= '0;
            mem_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (mem_arvalid && mem_arready) begin
                        raddr       <= mem_araddr;
                        rd_cnt      <= rd_load;
                        mem_arready <= 1'b0;
                        rd_state    <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    // Array is sampled on this edge, so a same-edge commit is not yet visible.
                    if (rd_cnt == '0) begin
                        rd_state   <= R_RESP;
                        mem_rvalid <= 1'b1;
                        mem_rdata  <= addr_ok(raddr) ? mem[word_idx(raddr)] : '0;
                        mem_rresp  <= addr_ok(raddr) ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        rd_cnt <= rd_cnt - 1'b1;
                    end
                end
                R_RESP: begin
                    if (mem_rready) begin
                        rd_state    <= R_IDLE;
                        mem_rvalid  <= 1'b0;
                        mem_arready <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // A lowered ready in W_IDLE means that channel was already captured.
    always_comb begin
        aw_got = !mem_awready || mem_awvalid;
        w_got  = !mem_wready  || mem_wvalid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state    <= W_IDLE;
            wr_cnt      <= '0;
            waddr       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            mem_awready <= 1'b1;
            mem_wready  <= 1'b1;
            mem_bvalid  <= 1'b0;
            mem_bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (mem_awvalid && mem_awready) begin
                        waddr       <= mem_awaddr;
                        mem_awready <= 1'b0;
                    end
                    if (mem_wvalid && mem_wready) begin
                        wdata_q    <= mem_wdata;
                        wstrb_q    <= mem_wstrb[3:0];
                        mem_wready <= 1'b0;
                    end
                    if (aw_got && w_got) begin
                        wr_cnt   <= wr_load;
                        wr_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (wr_cnt == '0) begin
                        wr_state   <= W_RESP;
                        mem_bvalid <= 1'b1;
                        mem_bresp  <= addr_ok(waddr) ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        wr_cnt <= wr_cnt - 1'b1;
                    end
                end
                W_RESP: begin
                    if (mem_bready) begin
                        wr_state    <= W_IDLE;
                        mem_bvalid  <= 1'b0;
                        mem_awready <= 1'b1;
                        mem_wready  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign wr_commit = (wr_state == W_WAIT) && (wr_cnt == '0) && addr_ok(waddr);

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[word_idx(waddr)][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule
